pipe_ctl_fsm: RTL and testbench
===============================

// Module: pipe_ctl_fsm
// PURPOSE
//  Central pipeline-control state machine for the mips789 core: decodes id_cmd from ID stage, drives
//  ID->RA / RA->EXEC register clear/hold strobes and PC pre-control. Parametrised successor of the
//  single-IRQ controller: N masked, prioritised interrupt lines; separate MUL/DIV/LD stall lengths;
//  optional early exit from multi-cycle stalls on md_done.
// PARAMETERS
//  N_IRQ      4   number of interrupt request lines (1..16)
//  MUL_DLY    35  total stall cycles for ID_MUL (>=1)
//  DIV_DLY    38  total stall cycles for ID_DIV (>=1)
//  LD_DLY     1   total stall cycles for ID_LD (>=1)
//  EARLY_EXIT 1   1: md_done terminates MUL/DIV stall; 0: md_done ignored
// PORTS
//  clk             in  1        core clock, rising edge
//  rst             in  1        asynchronous reset, active-low
//  id_cmd          in  3        ID-stage command: 0 none,1 CUR,2 MUL,3 DIV,4 RET,5 LD,6 NOI,7 none
//  irq             in  N_IRQ    level-sensitive interrupt requests
//  irq_mask        in  N_IRQ    1 = line masked
//  md_done         in  1        mul/div unit result ready (pulse)
//  pc_prectl       out 4        PC control: 1 IGN, 2 KEP, 4 IRQ, 8 RST (one-hot)
//  id2ra_ins_clr   out 1        clear ID->RA instruction register
//  id2ra_ins_cls   out 1        hold ID->RA instruction register
//  id2ra_ctl_clr   out 1        clear ID->RA control register
//  id2ra_ctl_cls   out 1        hold ID->RA control register
//  ra2exec_ctl_clr out 1        clear RA->EXEC control register
//  zz_is_nop       out 1        current issue slot is a bubble
//  iack            out 1        in interrupt service (registered in_isr)
//  irq_id          out clog2(N_IRQ) (min 1)  index of accepted interrupt, registered
// BEHAVIOUR
//  States: RST, IDLE, NOI, CUR, MD (mul/div stall), LD, IRQ, RET. Outputs Moore-decoded from state:
//   state | ins_clr ins_cls ctl_clr ctl_cls ra2ex_clr | pc  | nop
//   RST   |   1       0       1       0        1      |  8  |  1
//   IDLE  |   0       0       0       0        0      |  1  |  0     (NOI, RET identical)
//   CUR   |   0       1       0       1        1      |  2  |  1
//   MD    |   1       0       1       0        0      |  2  |  1
//   LD    |   1       0       1       0        0      |  2  |  0
//   IRQ   |   1       0       1       0        1      |  4  |  0
//  Reset (rst=0, async): state=RST, cnt=0, in_isr=0, irq_id=0; outputs = RST row, iack=0. rst=1 -> IDLE next edge.
//  pend = irq & ~irq_mask. From IDLE/NOI, priority order:
//   1) |pend && !in_isr -> IRQ; irq_id <= lowest set index of pend; in_isr <= 1 on that edge.
//   2) id_cmd 6->NOI, 1->CUR, 2->MD (cnt<=MUL_DLY-1), 3->MD (cnt<=DIV_DLY-1), 5->LD (cnt<=LD_DLY-1),
//      4->RET, 0/7->IDLE.
//  CUR -> NOI (one cycle). IRQ -> IDLE (one cycle). RET -> IDLE; in_isr <= 0 on entry to RET
//   (iack low from first RET cycle); RET with in_isr=0 harmless.
//  MD/LD: cnt==0 -> IDLE else cnt<=cnt-1 and stay; state lasts exactly *_DLY cycles.
//   MD with EARLY_EXIT=1 and md_done=1 -> IDLE next edge regardless of cnt. LD ignores md_done.
//  IRQ arriving during CUR/MD/LD/IRQ/RET is not taken; level sampled again in IDLE/NOI. Dropped
//   requests are lost (no latching). No nesting: pend ignored while in_isr=1.
//  Counter width CNT_W = clog2(max(MUL_DLY,DIV_DLY,LD_DLY)); no wrap, never decrements below 0.
//  Illegal state encoding -> RST next edge. iack == in_isr register; irq_id holds until next accept.
// STRUCTURE
//  mips789_defs: state encodings, ID_* command codes, PC_IGN/KEP/IRQ/RST constants.
//  Sub-module ctl_dly_cnt: loadable down-counter (load, value, dec, zero flag), parametrised CNT_W.
//  Top: state reg, next-state logic, Moore output decode, priority encoder, in_isr/irq_id regs.
// TESTING
//  rst low mid-MD (cnt=17) -> same cycle pc_prectl=8, nop=1, iack=0; after release IDLE, pc=1.
//  id_cmd=2, MUL_DLY=35, md_done=0 -> pc_prectl=2 exactly 35 cycles, then 1; ins/ctl_clr high throughout.
//  id_cmd=3 with md_done pulsed on 5th MD cycle (EARLY_EXIT=1) -> IDLE after 5 MD cycles; EARLY_EXIT=0 -> 38.
//  irq=4'b1010, mask=4'b0010 in IDLE -> IRQ one cycle pc=4, irq_id=3, iack=1; irq held -> no re-entry until RET.
//  id_cmd=1 -> CUR (ins_cls=ctl_cls=ra2exec_clr=1, pc=2, nop=1) then NOI; id_cmd=5 -> LD 1 cycle, nop=0.
//  irq asserted during 35-cycle MD -> taken on first IDLE cycle; id_cmd=4 -> RET, iack drops, irq_id held.

Source files
------------

// File: rtl/pipe_ctl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctl_fsm_pkg
// Purpose  : Shared definitions for the mips789 pipeline controller: state
//            encodings, ID-stage command codes, PC pre-control codes and the
//            Moore output decode used by the control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctl_fsm_pkg;

    // Controller states; all eight 3-bit codes are assigned.
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_NOI  = 3'd2,
        ST_CUR  = 3'd3,
        ST_MD   = 3'd4,
        ST_LD   = 3'd5,
        ST_IRQ  = 3'd6,
        ST_RET  = 3'd7
    } state_e;

    // ID-stage command codes (0 and 7 both mean "no command").
    localparam logic [2:0] ID_CUR = 3'd1;
    localparam logic [2:0] ID_MUL = 3'd2;
    localparam logic [2:0] ID_DIV = 3'd3;
    localparam logic [2:0] ID_RET = 3'd4;
    localparam logic [2:0] ID_LD  = 3'd5;
    localparam logic [2:0] ID_NOI = 3'd6;

    // One-hot PC pre-control codes.
    localparam logic [3:0] PC_IGN = 4'd1;
    localparam logic [3:0] PC_KEP = 4'd2;
    localparam logic [3:0] PC_IRQ = 4'd4;
    localparam logic [3:0] PC_RST = 4'd8;

    // Bundle of all state-decoded control outputs.
    typedef struct packed {
        logic [3:0] pc;
        logic       ins_clr;
        logic       ins_cls;
        logic       ctl_clr;
        logic       ctl_cls;
        logic       ra2exec_clr;
        logic       nop;
    } ctl_out_t;

    // Moore output table, one row per state.
    function automatic ctl_out_t decode_state(input state_e st);
        ctl_out_t o;
        o = '{pc: PC_IGN, default: 1'b0};
        case (st)
            ST_RST:  o = '{pc: PC_RST, ins_clr: 1'b1, ins_cls: 1'b0, ctl_clr: 1'b1,
                           ctl_cls: 1'b0, ra2exec_clr: 1'b1, nop: 1'b1};
            ST_CUR:  o = '{pc: PC_KEP, ins_clr: 1'b0, ins_cls: 1'b1, ctl_clr: 1'b0,
                           ctl_cls: 1'b1, ra2exec_clr: 1'b1, nop: 1'b1};
            ST_MD:   o = '{pc: PC_KEP, ins_clr: 1'b1, ins_cls: 1'b0, ctl_clr: 1'b1,
                           ctl_cls: 1'b0, ra2exec_clr: 1'b0, nop: 1'b1};
            ST_LD:   o = '{pc: PC_KEP, ins_clr: 1'b1, ins_cls: 1'b0, ctl_clr: 1'b1,
                           ctl_cls: 1'b0, ra2exec_clr: 1'b0, nop: 1'b0};
            ST_IRQ:  o = '{pc: PC_IRQ, ins_clr: 1'b1, ins_cls: 1'b0, ctl_clr: 1'b1,
                           ctl_cls: 1'b0, ra2exec_clr: 1'b1, nop: 1'b0};
            default: o = '{pc: PC_IGN, default: 1'b0};  // IDLE, NOI, RET
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctl_fsm_dly_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctl_fsm_dly_cnt
// Purpose  : Loadable down-counter timing multi-cycle stalls. Load wins over
//            decrement; the count saturates at zero instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctl_fsm_dly_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load, or step down while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_ctl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctl_fsm
// Purpose  : mips789 pipeline-control FSM. Decodes the ID-stage command,
//            drives ID->RA / RA->EXEC clear/hold strobes and PC pre-control,
//            accepts one masked, prioritised interrupt at a time and times
//            MUL/DIV/LD stalls (optionally cut short by md_done).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctl_fsm
    import pipe_ctl_fsm_pkg::*;
#(
    parameter int N_IRQ      = 4,
    parameter int MUL_DLY    = 35,
    parameter int DIV_DLY    = 38,
    parameter int LD_DLY     = 1,
    parameter int EARLY_EXIT = 1,
    parameter int IRQ_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_cmd,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             md_done,
    output logic [3:0]       pc_prectl,
    output logic             id2ra_ins_clr,
    output logic             id2ra_ins_cls,
    output logic             id2ra_ctl_clr,
    output logic             id2ra_ctl_cls,
    output logic             ra2exec_ctl_clr,
    output logic             zz_is_nop,
    output logic             iack,
    output logic [IRQ_W-1:0] irq_id
);

    localparam int MAX_MD  = (MUL_DLY > DIV_DLY) ? MUL_DLY : DIV_DLY;
    localparam int MAX_DLY = (MAX_MD > LD_DLY) ? MAX_MD : LD_DLY;
    localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    // The counter is loaded with DLY-1 so that the stall state lasts DLY cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_DLY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_DLY - 1);
    localparam logic [CNT_W-1:0] LD_LOAD  = CNT_W'(LD_DLY - 1);

    state_e           state_d,  state_q;
    logic             in_isr_d, in_isr_q;
    logic [IRQ_W-1:0] irq_id_d, irq_id_q;
    ctl_out_t         outs_d,   outs_q;

    logic [N_IRQ-1:0] pend;
    logic             pend_any;
    logic [IRQ_W-1:0] pend_idx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign pend     = irq & ~irq_mask;
    assign pend_any = |pend;

    // Priority encoder: lowest-numbered unmasked request wins.
    always_comb begin
        pend_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pend_idx = IRQ_W'(i);
            end
        end
    end

    // Stall timer shared by the MUL/DIV and LD states.
    pipe_ctl_fsm_dly_cnt #(
        .CNT_W    (CNT_W)
    ) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, interrupt bookkeeping and timer control.
    always_comb begin
        state_d  = state_q;
        in_isr_d = in_isr_q;
        irq_id_d = irq_id_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_IDLE;
            ST_IDLE, ST_NOI: begin
                if (pend_any && !in_isr_q) begin
                    state_d  = ST_IRQ;
                    in_isr_d = 1'b1;
                    irq_id_d = pend_idx;
                end else begin
                    case (id_cmd)
                        ID_NOI: state_d = ST_NOI;
                        ID_CUR: state_d = ST_CUR;
                        ID_MUL: begin
                            state_d  = ST_MD;
                            cnt_load = 1'b1;
                            cnt_val  = MUL_LOAD;
                        end
                        ID_DIV: begin
                            state_d  = ST_MD;
                            cnt_load = 1'b1;
                            cnt_val  = DIV_LOAD;
                        end
                        ID_LD: begin
                            state_d  = ST_LD;
                            cnt_load = 1'b1;
                            cnt_val  = LD_LOAD;
                        end
                        ID_RET: begin
                            state_d  = ST_RET;
                            in_isr_d = 1'b0;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CUR: state_d = ST_NOI;
            ST_IRQ: state_d = ST_IDLE;
            ST_RET: state_d = ST_IDLE;
            ST_MD: begin
                if ((EARLY_EXIT != 0) && md_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase
        outs_d = decode_state(state_d);
    end

    // State, ISR flag, accepted id and registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RST;
            in_isr_q <= 1'b0;
            irq_id_q <= '0;
            outs_q   <= decode_state(ST_RST);
        end else begin
            state_q  <= state_d;
            in_isr_q <= in_isr_d;
            irq_id_q <= irq_id_d;
            outs_q   <= outs_d;
        end
    end

    assign pc_prectl       = outs_q.pc;
    assign id2ra_ins_clr   = outs_q.ins_clr;
    assign id2ra_ins_cls   = outs_q.ins_cls;
    assign id2ra_ctl_clr   = outs_q.ctl_clr;
    assign id2ra_ctl_cls   = outs_q.ctl_cls;
    assign ra2exec_ctl_clr = outs_q.ra2exec_clr;
    assign zz_is_nop       = outs_q.nop;
    assign iack            = in_isr_q;
    assign irq_id          = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctl_fsm
// Purpose  : Self-checking bench for pipe_ctl_fsm. Two instances share all
//            inputs: one with early exit on md_done, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctl_fsm;

    localparam int S_RST = 0, S_IDLE = 1, S_NOI = 2, S_CUR = 3;
    localparam int S_MD  = 4, S_LD   = 5, S_IRQ = 6, S_RET = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_cmd;
    logic [3:0] irq;
    logic [3:0] irq_mask;
    logic       md_done;

    logic [3:0] pc1, pc2;
    logic       insc1, insh1, ctlc1, ctlh1, rac1, nop1, ack1;
    logic       insc2, insh2, ctlc2, ctlh2, rac2, nop2, ack2;
    logic [1:0] id1, id2;

    wire [25:0] act = {pc1, insc1, insh1, ctlc1, ctlh1, rac1, nop1, ack1, id1,
                       pc2, insc2, insh2, ctlc2, ctlh2, rac2, nop2, ack2, id2};

    int         total = 0;
    int         bad   = 0;
    logic [25:0] exp_q[$];
    logic [25:0] want;

    always #5 clk = ~clk;

    pipe_ctl_fsm #(.N_IRQ(4), .MUL_DLY(35), .DIV_DLY(38), .LD_DLY(1), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst), .id_cmd(id_cmd), .irq(irq), .irq_mask(irq_mask),
        .md_done(md_done), .pc_prectl(pc1), .id2ra_ins_clr(insc1), .id2ra_ins_cls(insh1),
        .id2ra_ctl_clr(ctlc1), .id2ra_ctl_cls(ctlh1), .ra2exec_ctl_clr(rac1),
        .zz_is_nop(nop1), .iack(ack1), .irq_id(id1)
    );

    pipe_ctl_fsm #(.N_IRQ(4), .MUL_DLY(35), .DIV_DLY(38), .LD_DLY(1), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst(rst), .id_cmd(id_cmd), .irq(irq), .irq_mask(irq_mask),
        .md_done(md_done), .pc_prectl(pc2), .id2ra_ins_clr(insc2), .id2ra_ins_cls(insh2),
        .id2ra_ctl_clr(ctlc2), .id2ra_ctl_cls(ctlh2), .ra2exec_ctl_clr(rac2),
        .zz_is_nop(nop2), .iack(ack2), .irq_id(id2)
    );

    // Expected output vector of one instance: {pc, ins_clr, ins_cls, ctl_clr, ctl_cls, ra2exec_clr, nop, iack, irq_id}
    function automatic logic [12:0] row(input int st, input logic ak, input logic [1:0] id);
        logic [9:0] r;
        case (st)
            S_RST:   r = {4'd8, 6'b101011};
            S_CUR:   r = {4'd2, 6'b010111};
            S_MD:    r = {4'd2, 6'b101001};
            S_LD:    r = {4'd2, 6'b101000};
            S_IRQ:   r = {4'd4, 6'b101010};
            default: r = {4'd1, 6'b000000};
        endcase
        return {r, ak, id};
    endfunction

    function automatic logic [25:0] both(input int st, input logic ak, input logic [1:0] id);
        return {row(st, ak, id), row(st, ak, id)};
    endfunction

    // Drive one cycle of inputs, record the expected outputs, and advance past the edge.
    task automatic apply(input logic [2:0] c, input logic [3:0] iv, input logic [3:0] mk,
                         input logic m, input logic [25:0] e);
        @(negedge clk);
        id_cmd   = c;
        irq      = iv;
        irq_mask = mk;
        md_done  = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b1;
            apply(3'd0, 4'd0, 4'd0, 1'b0, (i < 2) ? both(S_RST, 1'b0, 2'd0) : both(S_IDLE, 1'b0, 2'd0));
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL reset step%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    task automatic test_cmds();
        logic [2:0] cm [7];
        int         st [7];
        cm = '{3'd1, 3'd0, 3'd0, 3'd6, 3'd7, 3'd5, 3'd0};
        st = '{S_CUR, S_NOI, S_IDLE, S_NOI, S_IDLE, S_LD, S_IDLE};
        for (int i = 0; i < 7; i++) begin
            apply(cm[i], 4'd0, 4'd0, (i == 6), both(st[i], 1'b0, 2'd0));
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL cmds step%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    task automatic test_irq_mask();
        logic [2:0] cm [13];
        logic [3:0] iv [13];
        logic [3:0] mk [13];
        int         st [13];
        logic       ak [13];
        logic [1:0] id [13];
        cm = '{3'd2, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd6, 3'd0, 3'd4, 3'd0};
        iv = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 4'hF, 4'h6, 4'h0, 4'h0, 4'h0};
        mk = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        st = '{S_IRQ, S_IDLE, S_IDLE, S_RET, S_IDLE, S_IRQ, S_IDLE, S_RET, S_IDLE,
               S_IRQ, S_IDLE, S_RET, S_IDLE};
        ak = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        id = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 13; i++) begin
            apply(cm[i], iv[i], mk[i], 1'b0, both(st[i], ak[i], id[i]));
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL irq_mask step%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    task automatic test_mul_irq();
        logic [2:0] c;
        logic [3:0] iv;
        logic [25:0] e;
        for (int i = 1; i <= 40; i++) begin
            c  = (i == 1) ? 3'd2 : ((i == 39) ? 3'd4 : 3'd0);
            iv = (i >= 10 && i <= 38) ? 4'b0100 : 4'b0000;
            if (i <= 35)      e = both(S_MD,   1'b0, 2'd1);
            else if (i == 36) e = both(S_IDLE, 1'b0, 2'd1);
            else if (i == 37) e = both(S_IRQ,  1'b1, 2'd2);
            else if (i == 38) e = both(S_IDLE, 1'b1, 2'd2);
            else if (i == 39) e = both(S_RET,  1'b0, 2'd2);
            else              e = both(S_IDLE, 1'b0, 2'd2);
            apply(c, iv, 4'd0, 1'b0, e);
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL mul_irq cycle%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    task automatic test_div_early();
        logic [25:0] e;
        for (int i = 1; i <= 39; i++) begin
            e = {row((i <= 5) ? S_MD : S_IDLE, 1'b0, 2'd2),
                 row((i <= 38) ? S_MD : S_IDLE, 1'b0, 2'd2)};
            apply((i == 1) ? 3'd3 : 3'd0, 4'd0, 4'd0, (i == 6), e);
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL div_early cycle%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    task automatic test_reset_mid_md();
        logic [25:0] e;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1)      e = both(S_IRQ,  1'b1, 2'd3);
            else if (i == 2) e = both(S_IDLE, 1'b1, 2'd3);
            else             e = both(S_MD,   1'b1, 2'd3);
            apply((i == 1) ? 3'd0 : ((i <= 3) ? 3'd2 : 3'd0),
                  (i == 1) ? 4'b1000 : 4'b0000, 4'd0, 1'b0, e);
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL rst_mid_md cycle%0d got=%h want=%h", i, act, want);
            end
        end
        // Asynchronous assertion mid-stall takes effect without a clock edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(both(S_RST, 1'b0, 2'd0));
        want = exp_q.pop_front();
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL rst_async got=%h want=%h", act, want);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) rst = 1'b1;
            apply(3'd0, 4'd0, 4'd0, 1'b0, (i == 0) ? both(S_RST, 1'b0, 2'd0) : both(S_IDLE, 1'b0, 2'd0));
            want = exp_q.pop_front();
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL rst_release step%0d got=%h want=%h", i, act, want);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        id_cmd   = 3'd0;
        irq      = 4'd0;
        irq_mask = 4'd0;
        md_done  = 1'b0;
        test_reset();
        test_cmds();
        test_irq_mask();
        test_mul_irq();
        test_div_early();
        test_reset_mid_md();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
